// File: rtl/bcrypt_pkg.sv
// rtl/bcrypt_pkg.sv - shared types and constants for the bcrypt Blowfish datapath
package bcrypt_pkg;

    typedef enum logic [2:0] {
        BF_IDLE,
        BF_PXOR,
        BF_LOOKUP,
        BF_WAIT,
        BF_MIX,
        BF_WHITEN_A,
        BF_WHITEN_B,
        BF_DONE
    } blowfish_state_t;

    // Hex digits of pi, the initial Blowfish P-array before key expansion.
    localparam logic [31:0] BF_P_INIT [0:17] = '{
        32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344,
        32'hA4093822, 32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89,
        32'h452821E6, 32'h38D01377, 32'hBE5466CF, 32'h34E90C6C,
        32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5, 32'hB5470917,
        32'h9216D5D9, 32'h8979FB1B
    };

    function automatic int sboxDw(input int sboxAw);
        return 32 << (8 - sboxAw);
    endfunction

endpackage

// File: rtl/blowfish_f.sv
// rtl/blowfish_f.sv - Blowfish F function over packed S-box SRAM words
module blowfish_f
    import bcrypt_pkg::*;
#(
    parameter int  SBOX_AW = 7,
    localparam int SBOX_DW = sboxDw(SBOX_AW)
) (
    input  logic [31:0]          xl,
    input  logic [4*SBOX_DW-1:0] sboxData,
    output logic [4*SBOX_AW-1:0] sboxAddr,
    output logic [31:0]          f
);

    logic [31:0] sWord [4];

    for (genvar k = 0; k < 4; k++) begin : g_bank
        logic [7:0]         sByte;
        logic [SBOX_DW-1:0] bank;

        assign sByte = xl[31-8*k -: 8];
        assign bank  = sboxData[k*SBOX_DW +: SBOX_DW];
        assign sboxAddr[k*SBOX_AW +: SBOX_AW] = sByte[7 -: SBOX_AW];

        // Low byte bits beyond the address pick one 32-bit entry out of the wide SRAM word.
        if (SBOX_AW < 8) begin : g_lane
            logic [7-SBOX_AW:0] lane;
            assign lane     = sByte[7-SBOX_AW:0];
            assign sWord[k] = bank[32*lane +: 32];
        end else begin : g_direct
            assign sWord[k] = bank;
        end
    end

    assign f = ((sWord[0] + sWord[1]) ^ sWord[2]) + sWord[3];

endmodule

// File: rtl/blowfish_round_engine.sv
// rtl/blowfish_round_engine.sv - handshaked multi-cycle Blowfish encryption engine
module blowfish_round_engine
    import bcrypt_pkg::*;
#(
    parameter int  ROUNDS   = 16,
    parameter int  SBOX_LAT = 1,
    parameter int  SBOX_AW  = 7,
    localparam int SBOX_DW  = sboxDw(SBOX_AW),
    localparam int PW       = $clog2(ROUNDS + 2)
) (
    input  logic                 clk,
    input  logic                 reset_l,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_l,
    input  logic [31:0]          in_r,
    input  logic                 in_salt_en,
    input  logic [63:0]          in_salt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_l,
    output logic [31:0]          out_r,
    output logic [PW-1:0]        p_idx,
    input  logic [31:0]          p_data,
    output logic                 sbox_en,
    output logic [4*SBOX_AW-1:0] sbox_addr,
    input  logic [4*SBOX_DW-1:0] sbox_data,
    output logic                 busy
);

    localparam logic [PW-1:0] LAST_ROUND = PW'(ROUNDS - 1);
    localparam logic [3:0]    WAIT_INIT  = 4'(SBOX_LAT - 1);

    blowfish_state_t state;
    logic [31:0]     regL;
    logic [31:0]     regR;
    logic [PW-1:0]   rnd;
    logic [3:0]      waitCnt;
    logic [31:0]     fOut;

    // Addresses follow L continuously, so they stay put from LOOKUP until MIX samples the data.
    blowfish_f #(.SBOX_AW(SBOX_AW)) u_f (
        .xl       (regL),
        .sboxData (sbox_data),
        .sboxAddr (sbox_addr),
        .f        (fOut)
    );

    assign in_ready  = (state == BF_IDLE) && !abort;
    assign out_valid = (state == BF_DONE);
    assign sbox_en   = (state == BF_LOOKUP);
    assign busy      = (state != BF_IDLE);

    always_comb begin
        p_idx = '0;
        case (state)
            BF_PXOR:     p_idx = rnd;
            BF_WHITEN_A: p_idx = PW'(ROUNDS);
            BF_WHITEN_B: p_idx = PW'(ROUNDS + 1);
            default:     p_idx = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state   <= BF_IDLE;
            regL    <= '0;
            regR    <= '0;
            rnd     <= '0;
            waitCnt <= '0;
            out_l   <= '0;
            out_r   <= '0;
        end else if (abort) begin
            state <= BF_IDLE;
        end else begin
            case (state)
                BF_IDLE: begin
                    if (in_valid) begin
                        regL  <= in_l ^ (in_salt_en ? in_salt[63:32] : 32'h0);
                        regR  <= in_r ^ (in_salt_en ? in_salt[31:0] : 32'h0);
                        rnd   <= '0;
                        state <= BF_PXOR;
                    end
                end
                BF_PXOR: begin
                    regL  <= regL ^ p_data;
                    state <= BF_LOOKUP;
                end
                BF_LOOKUP: begin
                    waitCnt <= WAIT_INIT;
                    state   <= (WAIT_INIT != 4'd0) ? BF_WAIT : BF_MIX;
                end
                BF_WAIT: begin
                    waitCnt <= waitCnt - 4'd1;
                    if (waitCnt == 4'd1) begin
                        state <= BF_MIX;
                    end
                end
                BF_MIX: begin
                    regL <= regR ^ fOut;
                    regR <= regL;
                    if (rnd == LAST_ROUND) begin
                        state <= BF_WHITEN_A;
                    end else begin
                        rnd   <= rnd + PW'(1);
                        state <= BF_PXOR;
                    end
                end
                BF_WHITEN_A: begin
                    out_r <= regL ^ p_data;
                    state <= BF_WHITEN_B;
                end
                BF_WHITEN_B: begin
                    out_l <= regR ^ p_data;
                    state <= BF_DONE;
                end
                BF_DONE: begin
                    if (out_ready) begin
                        state <= BF_IDLE;
                    end
                end
                default: state <= BF_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blowfish_round_engine.sv
// tb/tb_blowfish_round_engine.sv - self-checking bench for blowfish_round_engine
module tb_blowfish_round_engine;
    import bcrypt_pkg::*;

    localparam int ROUNDS  = 16;
    localparam int LAT     = 1;
    localparam int AW      = 7;
    localparam int DW      = 32 << (8 - AW);
    localparam int NL      = 1 << (8 - AW);
    localparam int PW      = $clog2(ROUNDS + 2);
    localparam int LATENCY = ROUNDS * (LAT + 2) + 2;

    logic            clk;
    logic            reset_l;
    logic            abort;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_l;
    logic [31:0]     in_r;
    logic            in_salt_en;
    logic [63:0]     in_salt;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_l;
    logic [31:0]     out_r;
    logic [PW-1:0]   p_idx;
    logic [31:0]     p_data;
    logic            sbox_en;
    logic [4*AW-1:0] sbox_addr;
    logic [4*DW-1:0] sbox_data;
    logic            busy;

    blowfish_round_engine #(.ROUNDS(ROUNDS), .SBOX_LAT(LAT), .SBOX_AW(AW)) dut (
        .clk        (clk),
        .reset_l    (reset_l),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_l       (in_l),
        .in_r       (in_r),
        .in_salt_en (in_salt_en),
        .in_salt    (in_salt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_l      (out_l),
        .out_r      (out_r),
        .p_idx      (p_idx),
        .p_data     (p_data),
        .sbox_en    (sbox_en),
        .sbox_addr  (sbox_addr),
        .sbox_data  (sbox_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int nTests = 0;
    int nFails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // P-array and logical S-boxes, 256 entries each, indexed by the full byte.
    logic [31:0] pmem [0:ROUNDS+1];
    logic [31:0] sbox [4][256];

    assign p_data = (int'(p_idx) < ROUNDS + 2) ? pmem[p_idx] : 32'h0;

    function automatic logic [DW-1:0] readWord(input int k, input logic [AW-1:0] a);
        logic [DW-1:0] w;
        w = '0;
        for (int l = 0; l < NL; l++) w[32*l +: 32] = sbox[k][int'(a) * NL + l];
        return w;
    endfunction

    logic [4*DW-1:0] rdWord;
    always_comb begin
        rdWord = '0;
        for (int k = 0; k < 4; k++) rdWord[k*DW +: DW] = readWord(k, sbox_addr[k*AW +: AW]);
    end

    // SRAM read pipeline: garbage everywhere except LAT edges after a strobe.
    logic [4*DW-1:0] sPipe [LAT];
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) sPipe[i] <= sPipe[i-1];
        sPipe[0] <= sbox_en ? rdWord : {(4*DW/32){$urandom}};
    end
    assign sbox_data = sPipe[LAT-1];

    function automatic logic [31:0] fModel(input logic [31:0] x);
        return ((sbox[0][x[31:24]] + sbox[1][x[23:16]]) ^ sbox[2][x[15:8]]) + sbox[3][x[7:0]];
    endfunction

    // Textbook Blowfish encryption; returns {out_l, out_r}.
    function automatic logic [63:0] encModel(input logic [31:0] lIn, input logic [31:0] rIn);
        logic [31:0] l, r, t;
        l = lIn;
        r = rIn;
        for (int i = 0; i < ROUNDS; i++) begin
            l = l ^ pmem[i];
            r = r ^ fModel(l);
            t = l; l = r; r = t;
        end
        t = l; l = r; r = t;
        r = r ^ pmem[ROUNDS];
        l = l ^ pmem[ROUNDS+1];
        return {l, r};
    endfunction

    function automatic logic [63:0] saltedModel(input logic [31:0] l, input logic [31:0] r,
                                                input logic se, input logic [63:0] salt);
        return encModel(l ^ (se ? salt[63:32] : 32'h0), r ^ (se ? salt[31:0] : 32'h0));
    endfunction

    logic [63:0] expQ [$];
    always @(negedge clk) begin
        if (!reset_l) begin
            expQ.delete();
        end else begin
            if (out_valid) begin
                if (expQ.size() == 0) chk("stray_out_valid", 64'(out_valid), 64'd0);
                else                  chk("scoreboard", {out_l, out_r}, expQ[0]);
            end
            if (busy && abort) begin
                if (expQ.size() > 0) void'(expQ.pop_front());
            end else if (out_valid && out_ready && expQ.size() > 0) begin
                void'(expQ.pop_front());
            end
            if (in_valid && in_ready) expQ.push_back(saltedModel(in_l, in_r, in_salt_en, in_salt));
        end
    end

    task automatic clearMem();
        for (int i = 0; i < ROUNDS + 2; i++) pmem[i] = 32'h0;
        for (int k = 0; k < 4; k++) for (int i = 0; i < 256; i++) sbox[k][i] = 32'h0;
    endtask

    task automatic randomMem();
        for (int i = 0; i < ROUNDS + 2; i++) pmem[i] = BF_P_INIT[i] ^ $urandom;
        for (int k = 0; k < 4; k++) for (int i = 0; i < 256; i++) sbox[k][i] = $urandom;
    endtask

    task automatic checkResetValues(input string name);
        chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({name, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({name, "_sbox_en"}, 64'(sbox_en), 64'd0);
        chk({name, "_busy"}, 64'(busy), 64'd0);
        chk({name, "_p_idx"}, 64'(p_idx), 64'd0);
        chk({name, "_sbox_addr"}, 64'(sbox_addr), 64'd0);
        chk({name, "_out"}, {out_l, out_r}, 64'd0);
    endtask

    task automatic sendBlock(input logic [31:0] l, input logic [31:0] r, input logic se,
                             input logic [63:0] salt, output int lat);
        in_l = l; in_r = r; in_salt_en = se; in_salt = salt; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_salt_en = 1'b0;
        lat = 0;
        while (!out_valid && lat < 1000) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic runCase(input string name, input logic [31:0] l, input logic [31:0] r,
                           input logic se, input logic [63:0] salt, input logic [63:0] want);
        int lat;
        chk({name, "_model"}, saltedModel(l, r, se, salt), want);
        sendBlock(l, r, se, salt, lat);
        chk({name, "_latency"}, 64'(lat), 64'(LATENCY));
        chk({name, "_out"}, {out_l, out_r}, want);
        @(posedge clk); #1;
        chk({name, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int lat;
        int seen;
        logic        stable;
        logic [63:0] held;

        reset_l = 1'b0; abort = 1'b0; in_valid = 1'b0; in_l = '0; in_r = '0;
        in_salt_en = 1'b0; in_salt = '0; out_ready = 1'b1;
        clearMem();
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        reset_l = 1'b1;
        @(posedge clk); #1;

        runCase("zero_ps", 32'h01234567, 32'h89ABCDEF, 1'b0, 64'h0, 64'h89ABCDEF_01234567);
        pmem[ROUNDS+1] = 32'hFFFFFFFF;
        runCase("p17_ones", 32'h01234567, 32'h89ABCDEF, 1'b0, 64'h0, 64'h76543210_01234567);
        clearMem();
        runCase("salt", 32'h0, 32'h0, 1'b1, 64'hFFFFFFFF_00000000, 64'h00000000_FFFFFFFF);

        // First LOOKUP with P0 = 0x81000000: address and one-cycle strobe.
        pmem[0] = 32'h81000000;
        sbox[0][8'h81] = 32'h10;
        sbox[0][8'h80] = 32'h20;
        in_l = 32'h0; in_r = 32'h0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("lookup_sbox_en", 64'(sbox_en), 64'd1);
        chk("lookup_bank0_addr", 64'(sbox_addr[AW-1:0]), 64'(8'h81 >> (8 - AW)));
        @(posedge clk); #1;
        chk("lookup_en_pulse", 64'(sbox_en), 64'd0);
        lat = 0;
        while (!out_valid && lat < 1000) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("lookup_out", {out_l, out_r}, 64'h00000000_81000000);
        @(posedge clk); #1;

        randomMem();
        for (int i = 0; i < 5; i++) begin
            sendBlock($urandom, $urandom, i[0], {$urandom, $urandom}, lat);
            chk("random_latency", 64'(lat), 64'(LATENCY));
            @(posedge clk); #1;
        end

        out_ready = 1'b0;
        sendBlock($urandom, $urandom, 1'b0, 64'h0, lat);
        held = {out_l, out_r};
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if ({out_l, out_r} !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        chk("backpressure_hold", 64'(stable), 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("backpressure_release", 64'(busy), 64'd0);

        in_l = $urandom; in_r = $urandom; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5 * (LAT + 2)) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        seen = 0;
        repeat (LATENCY + 10) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("abort_no_out", 64'(seen), 64'd0);

        abort = 1'b1; in_valid = 1'b1;
        #1;
        chk("abort_blocks_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("abort_blocks_accept", 64'(busy), 64'd0);
        abort = 1'b0; in_valid = 1'b0;

        in_l = $urandom; in_r = $urandom; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset_l = 1'b0;
        #1;
        checkResetValues("midreset");
        @(posedge clk); #1;
        reset_l = 1'b1;
        @(posedge clk); #1;

        sendBlock(32'hDEADBEEF, 32'h0BADF00D, 1'b1, 64'h01234567_89ABCDEF, lat);
        chk("recover_latency", 64'(lat), 64'(LATENCY));
        @(posedge clk); #1;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", nTests, nFails);
        $finish;
    end

endmodule
